// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    // Number of restoring iterations for the default 32-bit datapath.
    localparam int DIV_ITER = 32;

endpackage

// File: rtl/div_restore_step.sv
// One combinational radix-2 restoring division step.
// The partial remainder is shifted left, taking the next dividend bit from the top of q.
// The divisor is then trial-subtracted in WIDTH+1 bits.
// A clear borrow bit means the subtraction is kept and a 1 is shifted into q.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    // Trial subtraction, then either keep it or restore the shifted remainder.
    always_comb begin
        rem_shift = {r_i, q_i[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor_i};
        if (trial[WIDTH]) begin
            r_o = rem_shift[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end else begin
            r_o = trial[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider.
// This block is the responder side of the EX-stage divide handshake.
// A request is captured from IDLE and takes WIDTH single-bit steps in BUSY.
// The sign-corrected quotient and remainder are then presented with a one-cycle div_done pulse.
// Dropping div_begin while BUSY abandons the operation silently.
// Optional macro DIV_EARLY_OUT_EN finishes one edge after capture in two cases:
// a zero divisor, or a dividend smaller than the divisor.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_ITER,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_sign,
    input  logic             div_dividend_sign,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_done
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             sign_q, sign_d;
    logic             dsign_q, dsign_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

`ifdef DIV_EARLY_OUT_EN
    logic             early_q, early_d;
    logic [WIDTH-1:0] early_quot;
`endif

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_i      (r_q),
        .q_i      (q_q),
        .divisor_i(divisor_q),
        .r_o      (step_r),
        .q_o      (step_q)
    );

`ifdef DIV_EARLY_OUT_EN
    // Trivial raw quotient: all-ones for a zero divisor, else zero (dividend < divisor).
    // In both cases the raw remainder is the dividend, still held untouched in q_q.
    assign early_quot = (divisor_q == '0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
`endif

    // Next-state logic: capture, iterate, sign-fix on the last step, then pulse done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        divisor_d = divisor_q;
        sign_d    = sign_q;
        dsign_d   = dsign_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
`ifdef DIV_EARLY_OUT_EN
        early_d   = early_q;
`endif
        case (state_q)
            DIV_IDLE: begin
                if (div_begin) begin
                    r_d       = '0;
                    q_d       = div_dividend;
                    divisor_d = div_divisor;
                    sign_d    = div_sign;
                    dsign_d   = div_dividend_sign;
                    cnt_d     = '0;
                    state_d   = DIV_BUSY;
`ifdef DIV_EARLY_OUT_EN
                    early_d   = (div_divisor == '0) || (div_dividend < div_divisor);
`endif
                end
            end
            DIV_BUSY: begin
                if (!div_begin) begin
                    // Pipeline flush: drop the operation, keep the last results.
                    state_d = DIV_IDLE;
                end
`ifdef DIV_EARLY_OUT_EN
                else if (early_q) begin
                    quot_d  = sign_q  ? -early_quot : early_quot;
                    rem_d   = dsign_q ? -q_q : q_q;
                    done_d  = 1'b1;
                    state_d = DIV_DONE;
                end
`endif
                else begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        quot_d  = sign_q  ? -step_q : step_q;
                        rem_d   = dsign_q ? -step_r : step_r;
                        done_d  = 1'b1;
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, even mid-operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            divisor_q <= '0;
            sign_q    <= 1'b0;
            dsign_q   <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            divisor_q <= divisor_d;
            sign_q    <= sign_d;
            dsign_q   <= dsign_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= early_d;
`endif
        end
    end

    assign div_quotient  = quot_q;
    assign div_remainder = rem_q;
    assign div_done      = done_q;

endmodule
